dmem_port_arbiter: RTL

- Shares the single data_mem port between the processor core's load/store path and a host port used by the bench or loader for preload and readback.
- Two requesters: core and host. Arbitration is registered and round-robin with a burst cap.
- Produces the data_mem control signals, per-requester grants, registered read-data return with a valid strobe, and a core stall.
- Sits between Ctrl/ALU (core side) and data_mem.

---
 rtl/dmem_port_arbiter_pkg.sv | 39 +++
 rtl/dmem_port_arbiter_if.sv | 49 ++++
 rtl/dmem_arb_stats.sv | 28 ++
 rtl/dmem_port_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    HOST = 2'd2
  } owner_t;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  // Round-robin from idle, burst-capped when both sides contend.
  function automatic owner_t next_owner(
    input owner_t     owner,
    input owner_t     last,
    input logic       core_req,
    input logic       host_req,
    input logic [3:0] burst_cnt,
    input logic [3:0] burst_last
  );
    owner_t nxt;
    nxt = NONE;
    if (core_req && host_req) begin
      if (owner == NONE)
        nxt = (last == CORE) ? HOST : CORE;
      else if (burst_cnt < burst_last)
        nxt = owner;
      else
        nxt = (owner == CORE) ? HOST : CORE;
    end else if (core_req) begin
      nxt = CORE;
    end else if (host_req) begin
      nxt = HOST;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and data_mem.
interface dmem_port_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_addr, mem_we, mem_re, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_we, mem_re, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/dmem_arb_stats.sv
// Saturating transfer and core-wait counters for the data-memory arbiter.
module dmem_arb_stats (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        core_xfer,
  input  logic        host_xfer,
  input  logic        core_stall,
  output logic [15:0] core_xfer_cnt,
  output logic [15:0] host_xfer_cnt,
  output logic [15:0] core_wait_cnt
);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      core_xfer_cnt <= '0;
      host_xfer_cnt <= '0;
      core_wait_cnt <= '0;
    end else begin
      if (core_xfer && (core_xfer_cnt != 16'hFFFF))
        core_xfer_cnt <= core_xfer_cnt + 16'd1;
      if (host_xfer && (host_xfer_cnt != 16'hFFFF))
        host_xfer_cnt <= host_xfer_cnt + 16'd1;
      if (core_stall && (core_wait_cnt != 16'hFFFF))
        core_wait_cnt <= core_wait_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Registered round-robin arbiter sharing data_mem between core and host, with a burst cap.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = 4
) (
  input  logic CLK,
  input  logic reset_n,
  dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] core_xfer_cnt,
  output logic [15:0] host_xfer_cnt,
  output logic [15:0] core_wait_cnt
`endif
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  owner_t        owner, owner_nxt, last, last_nxt;
  logic [3:0]    burst_cnt, burst_nxt;
  logic          core_gnt, host_gnt, core_xfer, host_xfer, core_stall;
  logic          core_rvalid_q, host_rvalid_q;
  logic [DW-1:0] core_rdata_q, host_rdata_q;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          mem_we_d, mem_re_d;

  assign core_gnt   = (owner == CORE);
  assign host_gnt   = (owner == HOST);
  assign core_xfer  = bus.core_req && core_gnt;
  assign host_xfer  = bus.host_req && host_gnt;
  assign core_stall = bus.core_req && !core_gnt;

  assign bus.core_gnt    = core_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.core_stall  = core_stall;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.host_rdata  = host_rdata_q;

  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    if (core_xfer) begin
      mem_addr_d  = bus.core_addr;
      mem_wdata_d = bus.core_wdata;
      mem_we_d    = bus.core_we;
      mem_re_d    = !bus.core_we;
    end else if (host_xfer) begin
      mem_addr_d  = bus.host_addr;
      mem_wdata_d = bus.host_wdata;
      mem_we_d    = bus.host_we;
      mem_re_d    = !bus.host_we;
    end
  end

  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_re    = mem_re_d;

  // Burst count restarts whenever ownership moves or the port goes idle.
  always_comb begin
    owner_nxt = next_owner(owner, last, bus.core_req, bus.host_req, burst_cnt, BURST_LAST);
    last_nxt  = last;
    if (core_xfer)
      last_nxt = CORE;
    else if (host_xfer)
      last_nxt = HOST;
    burst_nxt = burst_cnt;
    if ((owner_nxt != owner) || (owner_nxt == NONE))
      burst_nxt = '0;
    else if ((core_xfer || host_xfer) && (burst_cnt < BURST_LAST))
      burst_nxt = burst_cnt + 4'd1;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= NONE;
      last      <= HOST;
      burst_cnt <= '0;
    end else begin
      owner     <= owner_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Read data is tagged by its issuer so a same-edge owner switch cannot misroute it.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      host_rdata_q  <= '0;
    end else begin
      core_rvalid_q <= core_xfer && !bus.core_we;
      host_rvalid_q <= host_xfer && !bus.host_we;
      if (core_xfer && !bus.core_we)
        core_rdata_q <= bus.mem_rdata;
      if (host_xfer && !bus.host_we)
        host_rdata_q <= bus.mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .CLK           (CLK),
    .reset_n       (reset_n),
    .core_xfer     (core_xfer),
    .host_xfer     (host_xfer),
    .core_stall    (core_stall),
    .core_xfer_cnt (core_xfer_cnt),
    .host_xfer_cnt (host_xfer_cnt),
    .core_wait_cnt (core_wait_cnt)
  );
`endif

endmodule
